// File: rtl/lif_pkg.sv
// Shared types, default parameters and the saturating adder for the LIF neuron array.
// Refractory behaviour is selected elsewhere with the LIF_REFRACTORY_EN macro.
package lif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lif_state_e;

    localparam int LIF_N_CH_DEF         = 4;
    localparam int LIF_W_DEF            = 8;
    localparam int LIF_LEAK_SHIFT_DEF   = 3;
    localparam int LIF_REFRAC_STEPS_DEF = 2;

    // Unsigned add clamped to 2^w-1; the 33-bit sum keeps the carry visible for w up to 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int w);
        logic [32:0] sum_full;
        logic [32:0] max_val;
        max_val  = (33'd1 << w) - 33'd1;
        sum_full = {1'b0, a} + {1'b0, b};
        return (sum_full > max_val) ? max_val[31:0] : sum_full[31:0];
    endfunction

endpackage

// File: rtl/lif_update_core.sv
// Combinational single-channel leaky integrate-and-fire update, shared across channels.
// Refractory ports and logic exist only when LIF_REFRACTORY_EN is defined.
import lif_pkg::*;

module lif_update_core #(
    parameter int W            = LIF_W_DEF,
    parameter int LEAK_SHIFT   = LIF_LEAK_SHIFT_DEF
`ifdef LIF_REFRACTORY_EN
    ,
    parameter int REFRAC_STEPS = LIF_REFRAC_STEPS_DEF,
    parameter int RW           = 2
`endif
) (
    input  logic [W-1:0]  v,
    input  logic [W-1:0]  cur,
    input  logic [W-1:0]  thr,
`ifdef LIF_REFRACTORY_EN
    input  logic [RW-1:0] refr,
    output logic [RW-1:0] refr_next,
`endif
    output logic [W-1:0]  v_next,
    output logic          fire
);

    logic [W-1:0] leaked;
    logic [W-1:0] sum;

    // v - (v >> LEAK_SHIFT) never underflows, so only the add needs clamping.
    assign leaked = v - (v >> LEAK_SHIFT);
    assign sum    = W'(sat_add(32'(leaked), 32'(cur), W));

    always_comb begin
        v_next = sum;
        fire   = 1'b0;
`ifdef LIF_REFRACTORY_EN
        refr_next = '0;
`endif
        if (sum >= thr) begin
            fire   = 1'b1;
            v_next = '0;
        end
`ifdef LIF_REFRACTORY_EN
        if (refr != '0) begin
            v_next    = '0;
            fire      = 1'b0;
            refr_next = refr - RW'(1);
        end else if (fire) begin
            refr_next = RW'(REFRAC_STEPS);
        end
`endif
    end

endmodule

// File: rtl/lif_neuron_array.sv
// Array of N_CH leaky integrate-and-fire neurons updated one per cycle by a shared datapath.
// Define LIF_REFRACTORY_EN to hold each channel for REFRAC_STEPS sweeps after it fires.
//
// state | meaning
// IDLE  | waiting for step; step snapshots inputs and clears spike
// RUN   | updating channel idx, one per cycle
// DONE  | done pulse; step ignored here
import lif_pkg::*;

module lif_neuron_array #(
    parameter int N_CH         = LIF_N_CH_DEF,
    parameter int W            = LIF_W_DEF,
    parameter int LEAK_SHIFT   = LIF_LEAK_SHIFT_DEF,
    parameter int REFRAC_STEPS = LIF_REFRAC_STEPS_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     step,
    input  logic [N_CH*W-1:0]        current_in,
    input  logic [W-1:0]             threshold,
    input  logic [$clog2(N_CH)-1:0]  sel,
    output logic                     busy,
    output logic                     done,
    output logic [N_CH-1:0]          spike,
    output logic [W-1:0]             state_out
);

    localparam int IW = $clog2(N_CH);

    lif_state_e   state;
    lif_state_e   state_nxt;
    logic         accept;
    logic         upd_en;

    logic [IW-1:0] idx;
    logic [W-1:0]  cur_snap [N_CH];
    logic [W-1:0]  thr_snap;
    logic [W-1:0]  mem      [N_CH];
    logic [W-1:0]  v_next;
    logic          fire;

`ifdef LIF_REFRACTORY_EN
    localparam int RW = $clog2(REFRAC_STEPS + 1);
    logic [RW-1:0] refr_q [N_CH];
    logic [RW-1:0] refr_next;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        upd_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (step) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                upd_en = 1'b1;
                if (idx == IW'(N_CH - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    lif_update_core #(
        .W            (W),
        .LEAK_SHIFT   (LEAK_SHIFT)
`ifdef LIF_REFRACTORY_EN
        ,
        .REFRAC_STEPS (REFRAC_STEPS),
        .RW           (RW)
`endif
    ) u_core (
        .v         (mem[idx]),
        .cur       (cur_snap[idx]),
        .thr       (thr_snap),
`ifdef LIF_REFRACTORY_EN
        .refr      (refr_q[idx]),
        .refr_next (refr_next),
`endif
        .v_next    (v_next),
        .fire      (fire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            idx       <= '0;
            thr_snap  <= '0;
            spike     <= '0;
            state_out <= '0;
            for (int k = 0; k < N_CH; k++) begin
                cur_snap[k] <= '0;
                mem[k]      <= '0;
`ifdef LIF_REFRACTORY_EN
                refr_q[k]   <= '0;
`endif
            end
        end else begin
            state_out <= mem[sel];
            if (accept) begin
                idx      <= '0;
                thr_snap <= threshold;
                spike    <= '0;
                for (int k = 0; k < N_CH; k++) begin
                    cur_snap[k] <= current_in[k*W +: W];
                end
            end
            if (upd_en) begin
                mem[idx]    <= v_next;
                spike[idx]  <= fire;
`ifdef LIF_REFRACTORY_EN
                refr_q[idx] <= refr_next;
`endif
                idx         <= idx + IW'(1);
            end
        end
    end

endmodule
